// File: rtl/atm_pkg.sv
// Shared types and defaults for the ATM session controller and its PIN buffer.
package atm_pkg;

    typedef enum logic [2:0] {
        ESPERANDO_TARJETA = 3'd0,
        VERIFICAR_PIN     = 3'd1,
        SESION            = 3'd2,
        BLOQUEO           = 3'd3,
        FUERA_SERVICIO    = 3'd4   // spare encoding; the FSM recovers from it to ESPERANDO_TARJETA
    } atm_state_e;

    localparam logic RETIRO   = 1'b1;
    localparam logic DEPOSITO = 1'b0;

    localparam logic [15:0]     PIN_DEFAULT      = 16'h4756;
    localparam longint unsigned INIT_BAL_DEFAULT = 4500;

    function automatic logic sesion_activa(input atm_state_e s);
        return (s == VERIFICAR_PIN) || (s == SESION);
    endfunction

endpackage

// File: rtl/atm_pin_buffer.sv
// PIN digit shift register (MSD first) with a saturating digit count and
// comparison against the configured PIN.
module atm_pin_buffer
    import atm_pkg::*;
#(
    parameter int unsigned             PIN_DIGITS   = 4,
    parameter logic [4*PIN_DIGITS-1:0] PIN_CORRECTO = PIN_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       shift_i,
    input  logic [3:0] digit_i,
    input  logic       clear_i,
    output logic       match_o
);

    localparam int unsigned CNT_W = $clog2(PIN_DIGITS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(PIN_DIGITS);

    logic [4*PIN_DIGITS-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (shift_i && (cnt_q != FULL)) begin
            buf_d = (buf_q << 4) | (4*PIN_DIGITS)'(digit_i);
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign match_o = (cnt_q == FULL) && (buf_q == PIN_CORRECTO);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card detection, PIN entry with lockout, and a
// deposit/withdrawal session with limits, overflow guard and inactivity timeout.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned             PIN_DIGITS   = 4,
    parameter logic [4*PIN_DIGITS-1:0] PIN_CORRECTO = PIN_DEFAULT,
    parameter int unsigned             MAX_TRIES    = 3,
    parameter int unsigned             BAL_W        = 64,
    parameter int unsigned             AMT_W        = 32,
    parameter logic [BAL_W-1:0]        INIT_BAL     = BAL_W'(INIT_BAL_DEFAULT),
    parameter logic [BAL_W-1:0]        RETIRO_MAX   = BAL_W'(20000),
    parameter int unsigned             TIMEOUT_CYC  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tarjeta_recibida,
    input  logic             digito_stb,
    input  logic [3:0]       digito,
    input  logic             pin_stb,
    input  logic             monto_stb,
    input  logic             tipo_trans,
    input  logic [AMT_W-1:0] monto,
    input  logic             fin_sesion,
    output logic [BAL_W-1:0] balance,
    output logic             balance_actualizado,
    output logic             entregar_dinero,
    output logic             pin_incorrecto,
    output logic             advertencia,
    output logic             bloqueo,
    output logic             fondos_insuficientes,
    output logic             limite_excedido,
    output logic             deposito_rechazado,
    output logic             tiempo_agotado
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    atm_state_e       state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
    logic [BAL_W-1:0] bal_q, bal_d, ret_q, ret_d, monto_w;
    logic [TO_W-1:0]  to_q, to_d;
    logic [BAL_W:0]   dep_sum, ret_sum;
    logic upd_q, upd_d, ent_q, ent_d, inc_q, inc_d, adv_q, adv_d, blq_q, blq_d;
    logic fon_q, fon_d, lim_q, lim_d, rej_q, rej_d, tmo_q, tmo_d;
    logic pin_shift, pin_clear, pin_ok, actividad;

    atm_pin_buffer #(
        .PIN_DIGITS   (PIN_DIGITS),
        .PIN_CORRECTO (PIN_CORRECTO)
    ) u_pin (
        .clk_i   (clk),
        .rst_i   (rst),
        .shift_i (pin_shift),
        .digit_i (digito),
        .clear_i (pin_clear),
        .match_o (pin_ok)
    );

    assign monto_w   = BAL_W'(monto);
    assign dep_sum   = {1'b0, bal_q} + {1'b0, monto_w};
    assign ret_sum   = {1'b0, ret_q} + {1'b0, monto_w};
    assign tries_inc = tries_q + 1'b1;
    assign actividad = digito_stb | pin_stb | monto_stb;

    always_comb begin
        state_d   = state_q;
        tries_d   = tries_q;
        bal_d     = bal_q;
        ret_d     = ret_q;
        to_d      = '0;
        adv_d     = adv_q;
        blq_d     = blq_q;
        upd_d     = 1'b0;
        ent_d     = 1'b0;
        inc_d     = 1'b0;
        fon_d     = 1'b0;
        lim_d     = 1'b0;
        rej_d     = 1'b0;
        tmo_d     = 1'b0;
        pin_shift = 1'b0;
        pin_clear = 1'b0;

        case (state_q)
            ESPERANDO_TARJETA: begin
                pin_clear = 1'b1;
                if (tarjeta_recibida) state_d = VERIFICAR_PIN;
            end
            VERIFICAR_PIN: begin
                if (pin_stb) begin
                    pin_clear = 1'b1;
                    if (pin_ok) begin
                        tries_d = '0;
                        adv_d   = 1'b0;
                        ret_d   = '0;
                        state_d = SESION;
                    end else begin
                        tries_d = tries_inc;
                        inc_d   = 1'b1;
                        if (tries_inc == TRY_W'(MAX_TRIES - 1)) adv_d = 1'b1;
                        if (tries_inc == TRY_W'(MAX_TRIES)) begin
                            blq_d   = 1'b1;
                            state_d = BLOQUEO;
                        end
                    end
                end else begin
                    pin_shift = digito_stb;
                end
            end
            SESION: begin
                if (monto_stb) begin
                    case (tipo_trans)
                        DEPOSITO: begin
                            if (dep_sum[BAL_W]) begin
                                rej_d = 1'b1;
                            end else begin
                                bal_d = dep_sum[BAL_W-1:0];
                                upd_d = 1'b1;
                            end
                        end
                        RETIRO: begin
                            if (monto_w > bal_q) begin
                                fon_d = 1'b1;
                            end else if (ret_sum > {1'b0, RETIRO_MAX}) begin
                                lim_d = 1'b1;
                            end else begin
                                bal_d = bal_q - monto_w;
                                ret_d = ret_sum[BAL_W-1:0];
                                ent_d = 1'b1;
                                upd_d = 1'b1;
                            end
                        end
                    endcase
                end
                if (fin_sesion) state_d = ESPERANDO_TARJETA;
            end
            BLOQUEO: ;
            default: state_d = ESPERANDO_TARJETA;
        endcase

        // Inactivity: to_d defaults to zero, which covers every reload and exit.
        if (sesion_activa(state_q) && !actividad && !(state_q == SESION && fin_sesion)) begin
            if (to_q == TO_LAST) begin
                tmo_d   = 1'b1;
                state_d = ESPERANDO_TARJETA;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ESPERANDO_TARJETA;
            tries_q <= '0;
            bal_q   <= INIT_BAL;
            ret_q   <= '0;
            to_q    <= '0;
            upd_q   <= 1'b0;
            ent_q   <= 1'b0;
            inc_q   <= 1'b0;
            adv_q   <= 1'b0;
            blq_q   <= 1'b0;
            fon_q   <= 1'b0;
            lim_q   <= 1'b0;
            rej_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            bal_q   <= bal_d;
            ret_q   <= ret_d;
            to_q    <= to_d;
            upd_q   <= upd_d;
            ent_q   <= ent_d;
            inc_q   <= inc_d;
            adv_q   <= adv_d;
            blq_q   <= blq_d;
            fon_q   <= fon_d;
            lim_q   <= lim_d;
            rej_q   <= rej_d;
            tmo_q   <= tmo_d;
        end
    end

    assign balance              = bal_q;
    assign balance_actualizado  = upd_q;
    assign entregar_dinero      = ent_q;
    assign pin_incorrecto       = inc_q;
    assign advertencia          = adv_q;
    assign bloqueo              = blq_q;
    assign fondos_insuficientes = fon_q;
    assign limite_excedido      = lim_q;
    assign deposito_rechazado   = rej_q;
    assign tiempo_agotado       = tmo_q;

endmodule
